debug_loader: RTL
=================

Name: debug_loader

Overview:
- UART-side program loader for the pipelined MIPS debug unit; it handles the receive direction of the debug link.
- The debug unit serialises 32-bit values into bytes, MSB first, for UART TX. This block does the reverse: it assembles UART RX bytes, MSB first, into 32-bit instruction words and writes them sequentially into instruction memory.
- It terminates on an end-of-program word or on memory overflow, then returns a one-byte ACK or NAK over UART TX.

Parameters:
- NB, 32, instruction word / address width
- DATA_BITS, 8, UART byte width
- MEM_WORDS, 64, instruction memory capacity in words
- LOAD_CMD, 8'h6C, command byte ('l') that starts a load
- END_WORD, 32'hFFFF_FFFF, end-of-program marker word
- ACK_BYTE, 8'h06, reply after a successful load
- NAK_BYTE, 8'h15, reply after an overflow

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_uart_rx_ready  in  1  one-cycle pulse; i_uart_rx_data is valid this cycle
- i_uart_rx_data  in  DATA_BITS  received byte
- i_uart_tx_done  in  1  UART transmitter finished the current byte
- o_uart_tx_data  out  DATA_BITS  byte to transmit (registered)
- o_uart_tx_ready  out  1  transmit request (registered)
- o_imem_wr_en  out  1  instruction-memory write strobe
- o_imem_wr_addr  out  NB  byte address of the write
- o_imem_wr_data  out  NB  assembled instruction word
- o_loading  out  1  high while in RECV or WRITE
- o_load_done  out  1  one-cycle pulse at the end of a load
- o_overflow  out  1  sticky; the last load ran out of memory
- o_state_debug  out  4  current state encoding

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; byte count=0; assembly register=0; address=0; word count=0.
  - All outputs 0.
  - Asserting reset mid-operation discards any partial word and any pending TX. The next load starts at address 0.
- State encoding: IDLE=4'd0, RECV=4'd1, WRITE=4'd2, SEND_ACK=4'd3, DONE=4'd4. Any other value goes to IDLE on the next clock.
- IDLE:
  - An rx pulse with byte==LOAD_CMD moves to RECV.
  - On that transition: clear address, word count, byte count and o_overflow.
  - Rx pulses with any other byte are ignored.
- RECV, byte capture:
  - On each rx pulse: assembly register = {assembly[NB-DATA_BITS-1:0], byte}; byte count increments (2-bit, wraps).
  - The first byte received lands in bits [31:24].
- RECV, 4th byte (byte count==3 when the pulse arrives): byte count goes to 0 and the state moves to WRITE.
- Inside RECV, LOAD_CMD has no special meaning; it is treated as data.
- WRITE (exactly one cycle):
  - o_imem_wr_en=1; o_imem_wr_addr=current address; o_imem_wr_data=assembled word.
  - Write latency: the strobe is asserted in the cycle after the 4th byte's rx pulse.
  - Next cycle: address += 4; word count += 1.
  - If the word equals END_WORD: go to SEND_ACK with o_uart_tx_data=ACK_BYTE. The END_WORD itself is written.
  - Else if the incremented word count==MEM_WORDS: set o_overflow and go to SEND_ACK with o_uart_tx_data=NAK_BYTE.
  - Otherwise return to RECV.
  - An rx pulse arriving during WRITE is captured as the first byte of the next word.
- o_imem_wr_en is 0 in every state other than WRITE. Outside WRITE, addr and data hold their last values.
- SEND_ACK:
  - o_uart_tx_ready=1, with o_uart_tx_data stable, until i_uart_tx_done is seen.
  - On tx_done: drop o_uart_tx_ready on the next cycle and go to DONE.
  - Rx pulses in this state are ignored.
- DONE (one cycle): o_load_done=1, then go to IDLE.
- o_overflow stays set until the next accepted LOAD_CMD or reset.
- Address arithmetic: NB-bit, byte-addressed, always word-aligned (bits [1:0]=0).
- The last legal write address is 4*(MEM_WORDS-1); the address never reaches 4*MEM_WORDS.

Test Plan:
- Reset: hold i_reset=0 with random rx activity -> all outputs 0, o_state_debug=0, no writes.
- Nominal load: 6C,12,34,56,78,FF,FF,FF,FF -> two writes: addr 0 data 0x12345678, then addr 4 data 0xFFFFFFFF. Then tx_ready with data 0x06; after tx_done, o_load_done pulses once; state returns to 0.
- Ignored commands: 0x73, 0x00, 0xFF sent in IDLE -> no writes, state stays 0, no TX.
- Overflow, MEM_WORDS=4: 6C followed by 4 words of 0x00000001 -> writes at addr 0, 4, 8, 12; o_overflow=1; NAK 0x15 sent. A following 6C clears o_overflow.
- Mid-load reset: 6C,AA,BB, then pulse reset, then 6C,01,02,03,04,FF,FF,FF,FF -> first write is addr 0 data 0x01020304; no 0xAABB.. word ever appears.
- Delayed tx_done (100 cycles) -> tx_ready held high with data constant throughout; o_load_done only in the cycle after DONE is entered; rx bytes sent meanwhile cause no writes.

Source files
------------

// File: rtl/debug_loader.sv
// UART-side program loader: assembles RX bytes MSB-first into words,
// writes them to instruction memory, then replies with ACK or NAK.
module debug_loader #(
  parameter int          NB        = 32,
  parameter int          DATA_BITS = 8,
  parameter int          MEM_WORDS = 64,
  parameter logic [7:0]  LOAD_CMD  = 8'h6C,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_uart_rx_ready,
  input  logic [DATA_BITS-1:0] i_uart_rx_data,
  input  logic                 i_uart_tx_done,
  output logic [DATA_BITS-1:0] o_uart_tx_data,
  output logic                 o_uart_tx_ready,
  output logic                 o_imem_wr_en,
  output logic [NB-1:0]        o_imem_wr_addr,
  output logic [NB-1:0]        o_imem_wr_data,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_overflow,
  output logic [3:0]           o_state_debug
);

  localparam int WCW = $clog2(MEM_WORDS + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RECV  = 4'd1,
    S_WRITE = 4'd2,
    S_SEND  = 4'd3,
    S_DONE  = 4'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_byte_cnt;
  logic [NB-1:0]        r_asm;
  logic [NB-1:0]        r_addr;
  logic [WCW-1:0]       r_wcnt;
  logic [NB-1:0]        r_wr_addr;
  logic [NB-1:0]        r_wr_data;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_tx_ready;
  logic                 r_overflow;

  logic [NB-1:0]  w_word;
  logic [WCW-1:0] w_wcnt_inc;
  logic           w_is_end;
  logic           w_full;
  logic           w_cmd;

  assign w_word     = {r_asm[NB-DATA_BITS-1:0], i_uart_rx_data};
  assign w_wcnt_inc = r_wcnt + WCW'(1);
  assign w_is_end   = (r_wr_data == NB'(END_WORD));
  assign w_full     = (w_wcnt_inc == WCW'(MEM_WORDS));
  assign w_cmd      = i_uart_rx_ready &&
                      (i_uart_rx_data == DATA_BITS'(LOAD_CMD));

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd) w_next = S_RECV;
      S_RECV:  if (i_uart_rx_ready && r_byte_cnt == 2'd3)
                 w_next = S_WRITE;
      S_WRITE: w_next = (w_is_end || w_full) ? S_SEND : S_RECV;
      S_SEND:  if (i_uart_tx_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, address/count tracking, TX request
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_addr     <= '0;
      r_wcnt     <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_tx_data  <= '0;
      r_tx_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd) begin
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_byte_cnt <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_RECV: begin
          if (i_uart_rx_ready) begin
            r_asm      <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_wr_addr <= r_addr;
              r_wr_data <= w_word;
            end
          end
        end
        S_WRITE: begin
          if (i_uart_rx_ready) begin
            r_asm      <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          r_wcnt <= w_wcnt_inc;
          // Stop short of 4*MEM_WORDS once memory is full
          if (!w_full) r_addr <= r_addr + NB'(4);
          if (w_is_end) begin
            r_tx_data  <= DATA_BITS'(ACK_BYTE);
            r_tx_ready <= 1'b1;
          end else if (w_full) begin
            r_overflow <= 1'b1;
            r_tx_data  <= DATA_BITS'(NAK_BYTE);
            r_tx_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (i_uart_tx_done) r_tx_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_imem_wr_en    = (r_state == S_WRITE);
  assign o_imem_wr_addr  = r_wr_addr;
  assign o_imem_wr_data  = r_wr_data;
  assign o_uart_tx_data  = r_tx_data;
  assign o_uart_tx_ready = r_tx_ready;
  assign o_loading       = (r_state == S_RECV) || (r_state == S_WRITE);
  assign o_load_done     = (r_state == S_DONE);
  assign o_overflow      = r_overflow;
  assign o_state_debug   = r_state;

endmodule
